// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control sequencer: steps the shared datapath through
// FETCH/DECODE/EXEC/MEM/WB with memory handshake, bus timeout and illegal-opcode halt.
module multicycle_control #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [6:0]  i_OPCode,
  input  logic        i_mem_ready,
  output logic        o_IorD,
  output logic        o_MemRead,
  output logic        o_MemWrite,
  output logic        o_IRWrite,
  output logic        o_PCWrite,
  output logic        o_PCWriteCond,
  output logic        o_MemToReg,
  output logic [2:0]  o_ALUOp,
  output logic        o_ALUSrc1,
  output logic        o_ALUSrc2,
  output logic        o_RegWrite,
  output logic [2:0]  o_state,
  output logic        o_illegal,
  output logic        o_bus_error,
  output logic [31:0] o_instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam int N_LEGAL = 7;
  localparam logic [N_LEGAL*7-1:0] LEGAL_OPS =
    {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC};

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       pc_write_cond;
    logic       mem_to_reg;
    logic [2:0] alu_op;
    logic       alu_src1;
    logic       alu_src2;
    logic       reg_write;
  } ctrl_t;

  localparam ctrl_t CTRL_FETCH = '{mem_read: 1'b1, default: '0};

  state_t          state_reg, state_next;
  logic [6:0]      op_reg, op_next;
  logic [TO_W-1:0] to_cnt_reg;
  logic [31:0]     instret_reg;
  logic            illegal_reg;
  logic            bus_error_reg;
  ctrl_t           ctrl_reg, ctrl_next;

  logic [N_LEGAL-1:0] legal_hit;
  logic               opcode_legal;
  logic               mem_wait;
  logic               timed_out;
  logic               retire;

  generate
    for (genvar gi = 0; gi < N_LEGAL; gi++) begin : g_legal
      assign legal_hit[gi] = (i_OPCode == LEGAL_OPS[gi*7 +: 7]);
    end
  endgenerate

  assign opcode_legal = |legal_hit;
  assign mem_wait     = (state_reg == S_FETCH) || (state_reg == S_MEM);

  // Ready arriving in the limit cycle wins over the timeout.
  assign timed_out = (TIMEOUT_CYCLES != 0) && mem_wait && !i_mem_ready &&
                     (to_cnt_reg == TO_LIMIT);

  assign retire = ((state_reg == S_EXEC) && (op_reg == OP_BRANCH)) ||
                  ((state_reg == S_MEM) && (op_reg == OP_STORE) && i_mem_ready) ||
                  (state_reg == S_WB);

  always_comb begin
    state_next = state_reg;
    op_next    = op_reg;
    case (state_reg)
      S_FETCH: begin
        if (i_mem_ready)    state_next = S_DECODE;
        else if (timed_out) state_next = S_HALT;
      end
      S_DECODE: begin
        op_next    = i_OPCode;
        state_next = opcode_legal ? S_EXEC : S_HALT;
      end
      S_EXEC: begin
        case (op_reg)
          OP_BRANCH:         state_next = S_FETCH;
          OP_LOAD, OP_STORE: state_next = S_MEM;
          default:           state_next = S_WB;
        endcase
      end
      S_MEM: begin
        if (i_mem_ready)    state_next = (op_reg == OP_LOAD) ? S_WB : S_FETCH;
        else if (timed_out) state_next = S_HALT;
      end
      S_WB:    state_next = S_FETCH;
      default: state_next = S_HALT;
    endcase
  end

  // Control strobes are computed for the state being entered, so they come
  // straight from flops during that state.
  always_comb begin
    ctrl_next = '0;
    case (state_next)
      S_FETCH: ctrl_next.mem_read = 1'b1;
      S_EXEC: begin
        case (op_next)
          OP_R: ctrl_next.alu_op = 3'b010;
          OP_I: begin
            ctrl_next.alu_op   = 3'b011;
            ctrl_next.alu_src2 = 1'b1;
          end
          OP_LOAD, OP_STORE: begin
            ctrl_next.alu_op   = 3'b000;
            ctrl_next.alu_src2 = 1'b1;
          end
          OP_BRANCH: begin
            ctrl_next.alu_op        = 3'b001;
            ctrl_next.pc_write_cond = 1'b1;
          end
          OP_LUI: begin
            ctrl_next.alu_op   = 3'b100;
            ctrl_next.alu_src2 = 1'b1;
          end
          OP_AUIPC: begin
            ctrl_next.alu_op   = 3'b101;
            ctrl_next.alu_src1 = 1'b1;
            ctrl_next.alu_src2 = 1'b1;
          end
          default: ctrl_next.alu_op = 3'b000;
        endcase
      end
      S_MEM: begin
        ctrl_next.iord      = 1'b1;
        ctrl_next.alu_op    = 3'b000;
        ctrl_next.alu_src2  = 1'b1;
        ctrl_next.mem_read  = (op_next == OP_LOAD);
        ctrl_next.mem_write = (op_next == OP_STORE);
      end
      S_WB: begin
        ctrl_next.reg_write  = 1'b1;
        ctrl_next.mem_to_reg = (op_next == OP_LOAD);
      end
      default: ctrl_next = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg     <= S_FETCH;
      op_reg        <= '0;
      to_cnt_reg    <= '0;
      instret_reg   <= '0;
      illegal_reg   <= 1'b0;
      bus_error_reg <= 1'b0;
      ctrl_reg      <= CTRL_FETCH;
    end else begin
      state_reg <= state_next;
      op_reg    <= op_next;
      ctrl_reg  <= ctrl_next;
      if (state_next != state_reg)
        to_cnt_reg <= '0;
      else if (mem_wait && !i_mem_ready && (to_cnt_reg != '1))
        to_cnt_reg <= to_cnt_reg + 1'b1;
      if (retire)
        instret_reg <= instret_reg + 32'd1;
      if ((state_reg == S_DECODE) && !opcode_legal)
        illegal_reg <= 1'b1;
      if (timed_out)
        bus_error_reg <= 1'b1;
    end
  end

  // IR and PC must load in the very cycle the fetch data is valid.
  assign o_IRWrite     = (state_reg == S_FETCH) && i_mem_ready;
  assign o_PCWrite     = (state_reg == S_FETCH) && i_mem_ready;
  assign o_IorD        = ctrl_reg.iord;
  assign o_MemRead     = ctrl_reg.mem_read;
  assign o_MemWrite    = ctrl_reg.mem_write;
  assign o_PCWriteCond = ctrl_reg.pc_write_cond;
  assign o_MemToReg    = ctrl_reg.mem_to_reg;
  assign o_ALUOp       = ctrl_reg.alu_op;
  assign o_ALUSrc1     = ctrl_reg.alu_src1;
  assign o_ALUSrc2     = ctrl_reg.alu_src2;
  assign o_RegWrite    = ctrl_reg.reg_write;
  assign o_state       = state_reg;
  assign o_illegal     = illegal_reg;
  assign o_bus_error   = bus_error_reg;
  assign o_instret     = instret_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected control vectors are
// queued per scenario and compared against the DUT cycle by cycle.
module tb_multicycle_control;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic [6:0]  op;
  logic        o_IorD, o_MemRead, o_MemWrite, o_IRWrite, o_PCWrite, o_PCWriteCond;
  logic        o_MemToReg, o_ALUSrc1, o_ALUSrc2, o_RegWrite, o_illegal, o_bus_error;
  logic [2:0]  o_ALUOp, o_state;
  logic [31:0] o_instret;
  logic [17:0] obs;

  multicycle_control #(.TIMEOUT_CYCLES(4), .TO_W(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_OPCode(op), .i_mem_ready(ready),
    .o_IorD(o_IorD), .o_MemRead(o_MemRead), .o_MemWrite(o_MemWrite),
    .o_IRWrite(o_IRWrite), .o_PCWrite(o_PCWrite), .o_PCWriteCond(o_PCWriteCond),
    .o_MemToReg(o_MemToReg), .o_ALUOp(o_ALUOp), .o_ALUSrc1(o_ALUSrc1),
    .o_ALUSrc2(o_ALUSrc2), .o_RegWrite(o_RegWrite), .o_state(o_state),
    .o_illegal(o_illegal), .o_bus_error(o_bus_error), .o_instret(o_instret)
  );

  always #5 clk = ~clk;

  assign obs = {o_state, o_IorD, o_MemRead, o_MemWrite, o_IRWrite, o_PCWrite,
                o_PCWriteCond, o_MemToReg, o_ALUOp, o_ALUSrc1, o_ALUSrc2,
                o_RegWrite, o_illegal, o_bus_error};

  typedef struct {
    logic        rdy;
    logic [6:0]  opc;
    logic [17:0] ctrl;
    logic [31:0] ret;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Expected 16-bit strobe vector per state:
  // {state, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, MemToReg, ALUOp, Src1, Src2, RegWrite}
  function automatic logic [15:0] f_fetch(input logic r);
    return {3'd0, 1'b0, 1'b1, 1'b0, r, r, 1'b0, 1'b0, 3'b000, 3'b000};
  endfunction

  function automatic logic [15:0] f_decode();
    return {3'd1, 13'b0};
  endfunction

  function automatic logic [15:0] f_exec(input logic [6:0] opc);
    logic [2:0] a;
    logic s1, s2, pc;
    a = 3'b000; s1 = 1'b0; s2 = 1'b0; pc = 1'b0;
    case (opc)
      OP_R:              a = 3'b010;
      7'b0010011:        begin a = 3'b011; s2 = 1'b1; end
      OP_LOAD, OP_STORE: s2 = 1'b1;
      OP_BRANCH:         begin a = 3'b001; pc = 1'b1; end
      7'b0110111:        begin a = 3'b100; s2 = 1'b1; end
      OP_AUIPC:          begin a = 3'b101; s1 = 1'b1; s2 = 1'b1; end
      default:           a = 3'b000;
    endcase
    return {3'd2, 5'b00000, pc, 1'b0, a, s1, s2, 1'b0};
  endfunction

  function automatic logic [15:0] f_mem(input logic [6:0] opc);
    return {3'd3, 1'b1, (opc == OP_LOAD), (opc == OP_STORE), 4'b0000, 3'b000, 1'b0, 1'b1, 1'b0};
  endfunction

  function automatic logic [15:0] f_wb(input logic [6:0] opc);
    return {3'd4, 6'b000000, (opc == OP_LOAD), 3'b000, 1'b0, 1'b0, 1'b1};
  endfunction

  function automatic logic [15:0] f_halt();
    return {3'd5, 13'b0};
  endfunction

  function automatic void push(input logic r, input logic [6:0] opc, input logic [15:0] c,
                               input logic [1:0] flags, input logic [31:0] ret);
    exp_t e;
    e.rdy = r; e.opc = opc; e.ctrl = {c, flags}; e.ret = ret;
    sb.push_back(e);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ready = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ready = 1'b1; op = OP_R;
    repeat (2) @(posedge clk);
    @(negedge clk);
    ready = 1'b0;
    #1;
    n_tests++;
    if (obs !== {f_fetch(1'b0), 2'b00} || o_instret !== 32'd0) begin
      n_fail++;
      $display("FAIL reset: got ctrl=%h instret=%h, want ctrl=%h instret=0",
               obs, o_instret, {f_fetch(1'b0), 2'b00});
    end
    rst = 1'b0;
  endtask

  task automatic test_add();
    exp_t e;
    int cyc = 0;
    do_reset();
    push(1, OP_R, f_fetch(1), 2'b00, 0);
    push(1, OP_R, f_decode(), 2'b00, 0);
    push(1, OP_R, f_exec(OP_R), 2'b00, 0);
    push(1, OP_R, f_wb(OP_R), 2'b00, 0);
    push(0, OP_R, f_fetch(0), 2'b00, 1);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge clk); ready = e.rdy; op = e.opc; #1;
      n_tests++;
      if (obs !== e.ctrl || o_instret !== e.ret) begin
        n_fail++;
        $display("FAIL add cyc%0d: got ctrl=%h instret=%h, want ctrl=%h instret=%h",
                 cyc, obs, o_instret, e.ctrl, e.ret);
      end
      cyc++;
    end
  endtask

  task automatic test_load_wait();
    exp_t e;
    int cyc = 0;
    do_reset();
    push(1, OP_LOAD, f_fetch(1), 2'b00, 0);
    push(0, OP_LOAD, f_decode(), 2'b00, 0);
    push(0, OP_LOAD, f_exec(OP_LOAD), 2'b00, 0);
    for (int i = 0; i < 3; i++) push(0, OP_LOAD, f_mem(OP_LOAD), 2'b00, 0);
    push(1, OP_LOAD, f_mem(OP_LOAD), 2'b00, 0);
    push(0, OP_LOAD, f_wb(OP_LOAD), 2'b00, 0);
    push(0, OP_LOAD, f_fetch(0), 2'b00, 1);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge clk); ready = e.rdy; op = e.opc; #1;
      n_tests++;
      if (obs !== e.ctrl || o_instret !== e.ret) begin
        n_fail++;
        $display("FAIL load_wait cyc%0d: got ctrl=%h instret=%h, want ctrl=%h instret=%h",
                 cyc, obs, o_instret, e.ctrl, e.ret);
      end
      cyc++;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int cyc = 0;
    do_reset();
    push(1, OP_BRANCH, f_fetch(1), 2'b00, 0);
    push(0, OP_BRANCH, f_decode(), 2'b00, 0);
    push(1, OP_BRANCH, f_exec(OP_BRANCH), 2'b00, 0);
    push(1, OP_STORE, f_fetch(1), 2'b00, 1);
    push(1, OP_STORE, f_decode(), 2'b00, 1);
    push(0, OP_STORE, f_exec(OP_STORE), 2'b00, 1);
    push(1, OP_STORE, f_mem(OP_STORE), 2'b00, 1);
    push(0, OP_STORE, f_fetch(0), 2'b00, 2);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge clk); ready = e.rdy; op = e.opc; #1;
      n_tests++;
      if (obs !== e.ctrl || o_instret !== e.ret) begin
        n_fail++;
        $display("FAIL back_to_back cyc%0d: got ctrl=%h instret=%h, want ctrl=%h instret=%h",
                 cyc, obs, o_instret, e.ctrl, e.ret);
      end
      cyc++;
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    int cyc = 0;
    do_reset();
    push(1, OP_BAD, f_fetch(1), 2'b00, 0);
    push(0, OP_BAD, f_decode(), 2'b00, 0);
    for (int i = 0; i < 20; i++)
      push(1'($urandom_range(0, 1)), OP_BAD, f_halt(), 2'b10, 0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge clk); ready = e.rdy; op = e.opc; #1;
      n_tests++;
      if (obs !== e.ctrl || o_instret !== e.ret) begin
        n_fail++;
        $display("FAIL illegal cyc%0d: got ctrl=%h instret=%h, want ctrl=%h instret=%h",
                 cyc, obs, o_instret, e.ctrl, e.ret);
      end
      cyc++;
    end
    do_reset();
    n_tests++;
    if (o_state !== 3'd0 || o_illegal !== 1'b0 || obs !== {f_fetch(0), 2'b00}) begin
      n_fail++;
      $display("FAIL illegal_reset: got state=%0d illegal=%b ctrl=%h, want state=0 illegal=0 ctrl=%h",
               o_state, o_illegal, obs, {f_fetch(0), 2'b00});
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    int cyc = 0;
    // Phase 0: fetch timeout; phase 1: ready on the limit cycle; phase 2: MEM timeout.
    for (int ph = 0; ph < 3; ph++) begin
      do_reset();
      if (ph == 0) begin
        for (int i = 0; i < 5; i++) push(0, OP_R, f_fetch(0), 2'b00, 0);
        for (int i = 0; i < 3; i++) push(1'($urandom_range(0, 1)), OP_R, f_halt(), 2'b01, 0);
      end else if (ph == 1) begin
        for (int i = 0; i < 4; i++) push(0, OP_R, f_fetch(0), 2'b00, 0);
        push(1, OP_R, f_fetch(1), 2'b00, 0);
        push(0, OP_R, f_decode(), 2'b00, 0);
        push(0, OP_R, f_exec(OP_R), 2'b00, 0);
        push(0, OP_R, f_wb(OP_R), 2'b00, 0);
        push(0, OP_R, f_fetch(0), 2'b00, 1);
      end else begin
        push(1, OP_LOAD, f_fetch(1), 2'b00, 0);
        push(0, OP_LOAD, f_decode(), 2'b00, 0);
        push(0, OP_LOAD, f_exec(OP_LOAD), 2'b00, 0);
        for (int i = 0; i < 5; i++) push(0, OP_LOAD, f_mem(OP_LOAD), 2'b00, 0);
        for (int i = 0; i < 2; i++) push(1, OP_LOAD, f_halt(), 2'b01, 0);
      end
      while (sb.size() != 0) begin
        e = sb.pop_front();
        @(negedge clk); ready = e.rdy; op = e.opc; #1;
        n_tests++;
        if (obs !== e.ctrl || o_instret !== e.ret) begin
          n_fail++;
          $display("FAIL timeout ph%0d cyc%0d: got ctrl=%h instret=%h, want ctrl=%h instret=%h",
                   ph, cyc, obs, o_instret, e.ctrl, e.ret);
        end
        cyc++;
      end
    end
  endtask

  task automatic test_wrap_and_mid_reset();
    exp_t e;
    int cyc = 0;
    do_reset();
    force dut.instret_reg = 32'hFFFF_FFFF;
    #1 release dut.instret_reg;
    push(1, OP_AUIPC, f_fetch(1), 2'b00, 32'hFFFF_FFFF);
    push(1, OP_AUIPC, f_decode(), 2'b00, 32'hFFFF_FFFF);
    push(1, OP_AUIPC, f_exec(OP_AUIPC), 2'b00, 32'hFFFF_FFFF);
    push(1, OP_AUIPC, f_wb(OP_AUIPC), 2'b00, 32'hFFFF_FFFF);
    push(0, OP_AUIPC, f_fetch(0), 2'b00, 32'd0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge clk); ready = e.rdy; op = e.opc; #1;
      n_tests++;
      if (obs !== e.ctrl || o_instret !== e.ret) begin
        n_fail++;
        $display("FAIL wrap cyc%0d: got ctrl=%h instret=%h, want ctrl=%h instret=%h",
                 cyc, obs, o_instret, e.ctrl, e.ret);
      end
      cyc++;
    end
    do_reset();
    push(1, OP_LOAD, f_fetch(1), 2'b00, 0);
    push(0, OP_LOAD, f_decode(), 2'b00, 0);
    push(0, OP_LOAD, f_exec(OP_LOAD), 2'b00, 0);
    push(0, OP_LOAD, f_mem(OP_LOAD), 2'b00, 0);
    push(0, OP_LOAD, f_mem(OP_LOAD), 2'b00, 0);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      @(negedge clk); ready = e.rdy; op = e.opc; #1;
      n_tests++;
      if (obs !== e.ctrl || o_instret !== e.ret) begin
        n_fail++;
        $display("FAIL mid_reset_pre cyc%0d: got ctrl=%h instret=%h, want ctrl=%h instret=%h",
                 cyc, obs, o_instret, e.ctrl, e.ret);
      end
      cyc++;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (o_state !== 3'd0 || obs !== {f_fetch(0), 2'b00}) begin
      n_fail++;
      $display("FAIL mid_reset: got state=%0d ctrl=%h, want state=0 ctrl=%h",
               o_state, obs, {f_fetch(0), 2'b00});
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ready = 1'b0; op = 7'd0;
    test_reset();
    test_add();
    test_load_wait();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_wrap_and_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style sequencer for the multi-cycle RV32I core variant. Steps the shared datapath (ALU, register file, single unified memory port) through FETCH/DECODE/EXEC/MEM/WB.
- Drives the datapath control strobes from the current state and the latched opcode.
- Handles the memory ready handshake, a memory timeout, and an illegal-opcode halt.
- Counts retired instructions.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles to wait for i_mem_ready before a bus error. 0 disables the timeout.
- TO_W, 8: width of the timeout counter. Must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge
- i_rst  in  1  synchronous reset, active-high
- i_OPCode  in  7  instruction[6:0] from the instruction register; stable from DECODE onward
- i_mem_ready  in  1  memory has completed the current request this cycle
- o_IorD  out  1  memory address select: 0 = PC, 1 = ALU result
- o_MemRead  out  1  memory read request
- o_MemWrite  out  1  memory write request
- o_IRWrite  out  1  load instruction register
- o_PCWrite  out  1  unconditional PC update (PC+4)
- o_PCWriteCond  out  1  PC takes the branch target if the ALU branch condition is true
- o_MemToReg  out  1  register write-back source: 1 = memory data
- o_ALUOp  out  3  ALU operation class
- o_ALUSrc1  out  1  ALU operand A: 1 = PC
- o_ALUSrc2  out  1  ALU operand B: 1 = immediate
- o_RegWrite  out  1  register file write enable
- o_state  out  3  current state encoding
- o_illegal  out  1  sticky: illegal opcode seen
- o_bus_error  out  1  sticky: memory timeout
- o_instret  out  32  retired instruction count

Behaviour:
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Unlisted control outputs are 0 in every state. o_ALUOp is 000 outside EXEC and MEM.
- Reset (i_rst=1 at an edge):
  - State becomes FETCH; o_instret, the timeout counter, o_illegal and o_bus_error are cleared.
  - Reset has priority over every transition, including mid-wait. An outstanding memory request is abandoned.
  - After reset the outputs are FETCH values: o_MemRead=1, o_IorD=0.
- FETCH:
  - Asserts o_MemRead=1 and o_IorD=0.
  - If i_mem_ready=1: o_IRWrite=1 and o_PCWrite=1 in the same cycle; next state is DECODE.
  - Otherwise the state holds and the request stays asserted and stable.
- DECODE: one cycle. Legal opcodes go to EXEC. Any other opcode goes to HALT and sets o_illegal.
  - Legal opcodes: R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, LUI 0110111, AUIPC 0010111.
- EXEC: one cycle. o_ALUOp by opcode: R=010, I=011, LOAD/STORE=000, BRANCH=001, LUI=100, AUIPC=101.
  - o_ALUSrc2=1 for I, LOAD, STORE, LUI and AUIPC.
  - o_ALUSrc1=1 for AUIPC only.
  - BRANCH: o_PCWriteCond=1; the instruction retires; next state is FETCH.
  - LOAD and STORE go to MEM. R, I, LUI and AUIPC go to WB.
- MEM:
  - Keeps o_ALUOp=000 and o_ALUSrc2=1 so the address stays stable; o_IorD=1.
  - LOAD asserts o_MemRead; STORE asserts o_MemWrite.
  - The state holds until i_mem_ready=1. Then LOAD goes to WB; STORE retires and goes to FETCH.
- WB: one cycle, o_RegWrite=1. o_MemToReg=1 for LOAD, 0 otherwise. The instruction retires; next state is FETCH.
- Handshake:
  - i_mem_ready is ignored in states other than FETCH and MEM.
  - Same-cycle ready is legal, giving zero wait states.
  - Exactly one of o_MemRead or o_MemWrite is high in FETCH and MEM; neither is high in other states.
- Latency with zero-wait memory: BRANCH 3 cycles; R, I, LUI, AUIPC and STORE 4 cycles; LOAD 5 cycles.
- Timeout:
  - The counter is cleared on every state change.
  - In FETCH or MEM it increments each cycle with i_mem_ready=0.
  - If TIMEOUT_CYCLES≠0 and the counter equals TIMEOUT_CYCLES while ready is still 0: go to HALT and set o_bus_error.
  - i_mem_ready=1 in that same cycle wins, and no error is raised.
- o_instret:
  - Increments by 1 at the edge ending a retiring cycle.
  - Wraps 0xFFFFFFFF→0.
  - Does not count halted or illegal instructions.
- HALT: all control outputs are 0. The state holds until reset. o_illegal and o_bus_error hold their values.

Test Plan:
- Reset, then ADD (0110011) with i_mem_ready=1 always → states 0,1,2,4,0; in EXEC o_ALUOp=010 and o_ALUSrc2=0; o_RegWrite=1 only in WB; o_instret=1 after 4 cycles.
- LW (0000011), ready low for 3 cycles in MEM → MEM held 4 cycles with o_MemRead=1 and o_IorD=1 stable; WB has o_MemToReg=1; total 8 cycles; o_instret increments once.
- BEQ (1100011) then SW (0100011), zero wait → BEQ: o_PCWriteCond=1 in EXEC and 3 cycles total; SW: o_MemWrite=1 for one cycle, o_RegWrite never asserted, 4 cycles; o_instret=2.
- Opcode 1111111 → after DECODE o_state=5 and o_illegal=1; all strobes stay 0 for 20 cycles; i_rst then gives o_state=0 and o_illegal=0.
- TIMEOUT_CYCLES=4, ready held low in FETCH → HALT with o_bus_error=1 after the 5th FETCH cycle. Separately, ready arriving on that 5th cycle → DECODE with no error.
- Preload o_instret to 0xFFFFFFFF via forced retirements, run one AUIPC → o_instret=0; AUIPC EXEC shows o_ALUSrc1=1, o_ALUSrc2=1, o_ALUOp=101. Asserting i_rst in the middle of a MEM wait → o_state=0 on the next edge.
